bus_master_arbiter: RTL and testbench

- Round-robin arbiter that lets NumofMaster requesters share the single master port of the bus top (addr/trans in; rdata/resp/ready out).
- Sits between the masters (core instruction port, core data port, DMA) and the bus top.
- Sequences each transfer as ARB -> ADDR -> DATA and returns the slave response only to the owning master.
- A watchdog ends stalled data phases with an error response.

---
 rtl/bus_master_arbiter.sv | 149 ++++++++++++++
 tb/tb_bus_master_arbiter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter that shares one bus master port among several requesters.
// Each transfer runs ARB -> ADDR -> DATA, and a watchdog ends data phases that stall.
module bus_master_arbiter #(
    parameter int DWidth        = 32,
    parameter int NumofMaster   = 2,
    parameter int TimeoutCycles = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m_trans_i [0:NumofMaster-1],
    input  logic [DWidth-1:0] m_addr_i  [0:NumofMaster-1],
    output logic              m_grant_o [0:NumofMaster-1],
    output logic              m_ready_o [0:NumofMaster-1],
    output logic              m_resp_o  [0:NumofMaster-1],
    output logic [DWidth-1:0] m_rdata_o,
    output logic [DWidth-1:0] addr_o,
    output logic              trans_o,
    input  logic [DWidth-1:0] rdata_i,
    input  logic              resp_i,
    input  logic              ready_i
);
    localparam int IdxWidth = $clog2(NumofMaster);
    localparam int WdWidth  = $clog2(TimeoutCycles);

    typedef enum logic [1:0] {
        ST_ARB,
        ST_ADDR,
        ST_DATA
    } state_t;

    state_t              state_reg, state_next;
    logic [IdxWidth-1:0] ptr_reg, ptr_next;
    logic [IdxWidth-1:0] owner_reg, owner_next;
    logic [WdWidth-1:0]  wd_reg, wd_next;
    logic [DWidth-1:0]   addr_reg, addr_next;

    logic [NumofMaster-1:0] req_vec;
    logic [NumofMaster-1:0] owner_dec;
    logic [NumofMaster-1:0] other_req;
    logic [IdxWidth-1:0]    ptr_inc;
    logic [IdxWidth-1:0]    win;
    logic                   done_raw;
    logic                   done;
    logic                   done_resp;
    logic [DWidth-1:0]      done_rdata;

    // First set bit of req, scanning base, base+1, ... modulo NumofMaster.
    function automatic logic [IdxWidth-1:0] pick(
        input logic [NumofMaster-1:0] req,
        input logic [IdxWidth-1:0]    base
    );
        logic [IdxWidth-1:0] res;
        logic [IdxWidth-1:0] cand;
        logic                found;
        res   = base;
        found = 1'b0;
        for (int k = 0; k < NumofMaster; k++) begin
            cand = IdxWidth'((int'(base) + k) % NumofMaster);
            if (!found && req[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    generate
        for (genvar gi = 0; gi < NumofMaster; gi++) begin : g_master
            assign req_vec[gi]   = m_trans_i[gi];
            assign owner_dec[gi] = (owner_reg == IdxWidth'(gi));
            assign m_grant_o[gi] = (state_reg != ST_ARB) && owner_dec[gi];
            assign m_ready_o[gi] = done && owner_dec[gi];
            assign m_resp_o[gi]  = done && done_resp && owner_dec[gi];
        end
    endgenerate

    assign ptr_inc   = (owner_reg == IdxWidth'(NumofMaster - 1)) ? '0 : owner_reg + IdxWidth'(1);
    assign other_req = req_vec & ~owner_dec;
    assign win       = (state_reg == ST_DATA) ? pick(other_req, ptr_inc) : pick(req_vec, ptr_reg);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        wd_next    = wd_reg;
        addr_next  = addr_reg;
        done_raw   = 1'b0;
        done_resp  = 1'b0;
        done_rdata = '0;
        case (state_reg)
            ST_ARB: begin
                if (|req_vec) begin
                    owner_next = win;
                    addr_next  = m_addr_i[win];
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                wd_next    = '0;
                state_next = ST_DATA;
            end
            ST_DATA: begin
                wd_next = wd_reg + WdWidth'(1);
                if (ready_i) begin
                    done_raw   = 1'b1;
                    done_resp  = resp_i;
                    done_rdata = rdata_i;
                    ptr_next   = ptr_inc;
                    // Hand the bus straight to the next waiting master, skipping ARB.
                    if (|other_req) begin
                        owner_next = win;
                        addr_next  = m_addr_i[win];
                        state_next = ST_ADDR;
                    end else begin
                        state_next = ST_ARB;
                    end
                end else if (wd_reg == WdWidth'(TimeoutCycles - 1)) begin
                    done_raw   = 1'b1;
                    done_resp  = 1'b1;
                    ptr_next   = ptr_inc;
                    state_next = ST_ARB;
                end
            end
            default: state_next = ST_ARB;
        endcase
    end

    // A completion coinciding with reset is aborted, so no ready pulse escapes.
    assign done      = done_raw & ~rst_i;
    assign m_rdata_o = done ? done_rdata : '0;
    assign addr_o    = addr_reg;
    assign trans_o   = (state_reg == ST_ADDR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_ARB;
            ptr_reg   <= '0;
            owner_reg <= '0;
            wd_reg    <= '0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            wd_reg    <= wd_next;
            addr_reg  <= addr_next;
        end
    end
endmodule

// File: tb/tb_bus_master_arbiter.sv
// Scenario bench for bus_master_arbiter: expected completions are queued as
// stimulus is driven and popped when a master sees its ready pulse.
module tb_bus_master_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          m_trans_i [0:N-1];
    logic [DW-1:0] m_addr_i  [0:N-1];
    logic          m_grant_o [0:N-1];
    logic          m_ready_o [0:N-1];
    logic          m_resp_o  [0:N-1];
    logic [DW-1:0] m_rdata_o;
    logic [DW-1:0] addr_o;
    logic          trans_o;
    logic [DW-1:0] rdata_i;
    logic          resp_i;
    logic          ready_i;

    typedef struct {
        int          master;
        logic        resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bus_master_arbiter #(
        .DWidth(DW),
        .NumofMaster(N),
        .TimeoutCycles(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .m_trans_i(m_trans_i),
        .m_addr_i(m_addr_i),
        .m_grant_o(m_grant_o),
        .m_ready_o(m_ready_o),
        .m_resp_o(m_resp_o),
        .m_rdata_o(m_rdata_o),
        .addr_o(addr_o),
        .trans_o(trans_o),
        .rdata_i(rdata_i),
        .resp_i(resp_i),
        .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] gvec();
        return {m_grant_o[1], m_grant_o[0]};
    endfunction

    function automatic logic [1:0] rvec();
        return {m_ready_o[1], m_ready_o[0]};
    endfunction

    function automatic logic [1:0] svec();
        return {m_resp_o[1], m_resp_o[0]};
    endfunction

    function automatic int done_master();
        if (m_ready_o[0] === 1'b1) return 0;
        if (m_ready_o[1] === 1'b1) return 1;
        return -1;
    endfunction

    task automatic test_reset();
        @(posedge clk); #1;
        rst_i = 1'b1;
        m_trans_i[0] = 1'b1; m_trans_i[1] = 1'b1;
        m_addr_i[0] = 32'hAAAA_AAAA; m_addr_i[1] = 32'h5555_5555;
        ready_i = 1'b1; resp_i = 1'b1; rdata_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (trans_o !== 1'b0 || addr_o !== 32'h0) begin
            errors++; $display("FAIL reset_bus: trans_o=%b addr_o=%h, expected 0/0", trans_o, addr_o);
        end
        checks++;
        if (gvec() !== 2'b00) begin
            errors++; $display("FAIL reset_grant: got %b, expected 00", gvec());
        end
        checks++;
        if (rvec() !== 2'b00 || svec() !== 2'b00) begin
            errors++; $display("FAIL reset_ready_resp: ready=%b resp=%b, expected 00/00", rvec(), svec());
        end
        checks++;
        if (m_rdata_o !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h, expected 0", m_rdata_o);
        end
        m_trans_i[0] = 1'b0; m_trans_i[1] = 1'b0;
        ready_i = 1'b0; resp_i = 1'b0; rdata_i = 32'h0;
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        exp_t e;
        int   who;
        @(posedge clk); #1;
        m_addr_i[0] = 32'h0000_0010; m_trans_i[0] = 1'b1;
        ready_i = 1'b1; resp_i = 1'b0; rdata_i = 32'h0000_5555;
        exp_q.push_back('{0, 1'b0, 32'h0000_5555});
        @(negedge clk);
        checks++;
        if (trans_o !== 1'b0) begin
            errors++; $display("FAIL single_arb: trans_o=%b, expected 0", trans_o);
        end
        @(negedge clk);
        checks++;
        if (trans_o !== 1'b1 || addr_o !== 32'h10 || gvec() !== 2'b01) begin
            errors++; $display("FAIL single_addr: trans_o=%b addr_o=%h grant=%b, expected 1/10/01", trans_o, addr_o, gvec());
        end
        checks++;
        if (rvec() !== 2'b00) begin
            errors++; $display("FAIL single_ready_in_addr: ready=%b, expected 00", rvec());
        end
        @(negedge clk);
        who = done_master();
        checks++;
        if (who < 0 || exp_q.size() == 0) begin
            errors++; $display("FAIL single_done: master %0d, queue %0d, expected master 0", who, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            $display("txn master %0d resp %b rdata %h", who, m_resp_o[who], m_rdata_o);
            if (who !== e.master || m_resp_o[who] !== e.resp || m_rdata_o !== e.rdata) begin
                errors++; $display("FAIL single_done: master %0d resp %b rdata %h, expected %0d %b %h", who, m_resp_o[who], m_rdata_o, e.master, e.resp, e.rdata);
            end
        end
        @(posedge clk); #1;
        m_trans_i[0] = 1'b0; ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (trans_o !== 1'b0 || gvec() !== 2'b00) begin
            errors++; $display("FAIL single_idle: trans_o=%b grant=%b, expected 0/00", trans_o, gvec());
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        int   who;
        int   n_done = 0;
        int   first = -1;
        int   last = -1;
        logic [31:0] exp_addr;
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        m_addr_i[0] = 32'h0000_0100; m_addr_i[1] = 32'h0000_0200;
        m_trans_i[0] = 1'b1; m_trans_i[1] = 1'b1;
        ready_i = 1'b1; resp_i = 1'b0; rdata_i = 32'hA000_0000;
        for (int k = 0; k < 6; k++) exp_q.push_back('{k % 2, 1'b0, 32'hA000_0000 + k});
        for (int cyc = 0; cyc < 40 && n_done < 6; cyc++) begin
            @(negedge clk);
            if (trans_o === 1'b1) begin
                exp_addr = (n_done % 2 == 0) ? 32'h100 : 32'h200;
                checks++;
                if (addr_o !== exp_addr || gvec() !== ((n_done % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL rr_grant: addr_o=%h grant=%b, expected %h for master %0d", addr_o, gvec(), exp_addr, n_done % 2);
                end
            end
            who = done_master();
            if (who >= 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rr_done: unexpected completion by master %0d", who);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn master %0d resp %b rdata %h", who, m_resp_o[who], m_rdata_o);
                    if (who !== e.master || m_resp_o[who] !== e.resp || m_rdata_o !== e.rdata) begin
                        errors++; $display("FAIL rr_done: master %0d resp %b rdata %h, expected %0d %b %h", who, m_resp_o[who], m_rdata_o, e.master, e.resp, e.rdata);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                n_done++;
            end
            @(posedge clk); #1;
            rdata_i = 32'hA000_0000 + n_done;
            if (n_done >= 5) m_trans_i[0] = 1'b0;
            if (n_done >= 6) m_trans_i[1] = 1'b0;
        end
        checks++;
        if (n_done != 6) begin
            errors++; $display("FAIL rr_count: got %0d completions, expected 6", n_done);
        end
        checks++;
        if (last - first != 10) begin
            errors++; $display("FAIL rr_no_idle: span %0d cycles, expected 10", last - first);
        end
        ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (trans_o !== 1'b0 || gvec() !== 2'b00) begin
            errors++; $display("FAIL rr_idle: trans_o=%b grant=%b, expected 0/00", trans_o, gvec());
        end
    endtask

    task automatic test_wait();
        exp_t e;
        int   who;
        @(posedge clk); #1;
        m_addr_i[1] = 32'h0000_1004; m_trans_i[1] = 1'b1;
        ready_i = 1'b0; resp_i = 1'b0;
        exp_q.push_back('{1, 1'b0, 32'hDEAD_BEEF});
        @(posedge clk); #1;
        ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (trans_o !== 1'b1 || addr_o !== 32'h1004 || gvec() !== 2'b10 || rvec() !== 2'b00) begin
            errors++; $display("FAIL wait_addr: trans_o=%b addr_o=%h grant=%b ready=%b, expected 1/1004/10/00", trans_o, addr_o, gvec(), rvec());
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ready_i = 1'b0; rdata_i = 32'h0BAD_0000 + i;
            @(negedge clk);
            checks++;
            if (rvec() !== 2'b00 || gvec() !== 2'b10) begin
                errors++; $display("FAIL wait_state: cycle %0d ready=%b grant=%b, expected 00/10", i, rvec(), gvec());
            end
        end
        @(posedge clk); #1;
        ready_i = 1'b1; rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        who = done_master();
        checks++;
        if (who < 0 || exp_q.size() == 0 || rvec() !== 2'b10) begin
            errors++; $display("FAIL wait_done: ready=%b queue %0d, expected ready 10", rvec(), exp_q.size());
        end else begin
            e = exp_q.pop_front();
            $display("txn master %0d resp %b rdata %h", who, m_resp_o[who], m_rdata_o);
            if (who !== e.master || m_resp_o[who] !== e.resp || m_rdata_o !== e.rdata) begin
                errors++; $display("FAIL wait_done: master %0d resp %b rdata %h, expected %0d %b %h", who, m_resp_o[who], m_rdata_o, e.master, e.resp, e.rdata);
            end
        end
        @(posedge clk); #1;
        m_trans_i[1] = 1'b0; ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (rvec() !== 2'b00) begin
            errors++; $display("FAIL wait_pulse: ready=%b one cycle later, expected 00", rvec());
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   who;
        @(posedge clk); #1;
        m_addr_i[0] = 32'h0000_2000; m_trans_i[0] = 1'b1;
        ready_i = 1'b0; resp_i = 1'b0; rdata_i = 32'hFFFF_FFFF;
        exp_q.push_back('{0, 1'b1, 32'h0});
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (trans_o !== 1'b1 || gvec() !== 2'b01) begin
            errors++; $display("FAIL timeout_addr: trans_o=%b grant=%b, expected 1/01", trans_o, gvec());
        end
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            who = done_master();
            checks++;
            if (i < 16) begin
                if (who != -1) begin
                    errors++; $display("FAIL timeout_early: completion by %0d in DATA cycle %0d, expected none", who, i);
                end
            end else if (who < 0 || exp_q.size() == 0) begin
                errors++; $display("FAIL timeout_done: no completion in DATA cycle 16, expected master 0 error");
            end else begin
                e = exp_q.pop_front();
                $display("txn master %0d resp %b rdata %h", who, m_resp_o[who], m_rdata_o);
                if (who !== e.master || m_resp_o[who] !== e.resp || m_rdata_o !== e.rdata) begin
                    errors++; $display("FAIL timeout_done: master %0d resp %b rdata %h, expected %0d %b %h", who, m_resp_o[who], m_rdata_o, e.master, e.resp, e.rdata);
                end
            end
        end
        @(posedge clk); #1;
        m_trans_i[0] = 1'b0; ready_i = 1'b1;
        m_addr_i[1] = 32'h0000_3000; m_trans_i[1] = 1'b1; rdata_i = 32'h7777_0000;
        exp_q.push_back('{1, 1'b0, 32'h7777_0000});
        @(negedge clk);
        checks++;
        if (rvec() !== 2'b00 || trans_o !== 1'b0) begin
            errors++; $display("FAIL timeout_late_ready: ready=%b trans_o=%b, expected 00/0", rvec(), trans_o);
        end
        @(negedge clk);
        checks++;
        if (trans_o !== 1'b1 || addr_o !== 32'h3000 || gvec() !== 2'b10) begin
            errors++; $display("FAIL timeout_next_addr: trans_o=%b addr_o=%h grant=%b, expected 1/3000/10", trans_o, addr_o, gvec());
        end
        @(negedge clk);
        who = done_master();
        checks++;
        if (who < 0 || exp_q.size() == 0) begin
            errors++; $display("FAIL timeout_next_done: no completion, expected master 1");
        end else begin
            e = exp_q.pop_front();
            $display("txn master %0d resp %b rdata %h", who, m_resp_o[who], m_rdata_o);
            if (who !== e.master || m_resp_o[who] !== e.resp || m_rdata_o !== e.rdata) begin
                errors++; $display("FAIL timeout_next_done: master %0d resp %b rdata %h, expected %0d %b %h", who, m_resp_o[who], m_rdata_o, e.master, e.resp, e.rdata);
            end
        end
        @(posedge clk); #1;
        m_trans_i[1] = 1'b0; ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   who;
        @(posedge clk); #1;
        m_addr_i[0] = 32'h0000_0040; m_trans_i[0] = 1'b1;
        ready_i = 1'b1; resp_i = 1'b1; rdata_i = 32'h0000_4444;
        exp_q.push_back('{0, 1'b1, 32'h0000_4444});
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        who = done_master();
        checks++;
        if (who < 0 || exp_q.size() == 0) begin
            errors++; $display("FAIL rstmid_pre_done: no completion, expected master 0 with resp 1");
        end else begin
            e = exp_q.pop_front();
            $display("txn master %0d resp %b rdata %h", who, m_resp_o[who], m_rdata_o);
            if (who !== e.master || m_resp_o[who] !== e.resp || m_rdata_o !== e.rdata) begin
                errors++; $display("FAIL rstmid_pre_done: master %0d resp %b rdata %h, expected %0d %b %h", who, m_resp_o[who], m_rdata_o, e.master, e.resp, e.rdata);
            end
        end
        @(posedge clk); #1;
        m_trans_i[0] = 1'b0; m_addr_i[1] = 32'h0000_0050; m_trans_i[1] = 1'b1;
        ready_i = 1'b0; resp_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (gvec() !== 2'b10 || trans_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_data: grant=%b trans_o=%b, expected 10/0", gvec(), trans_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if (rvec() !== 2'b00) begin
            errors++; $display("FAIL rstmid_pulse: ready=%b during reset, expected 00", rvec());
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
        m_addr_i[0] = 32'h0000_0060; m_trans_i[0] = 1'b1; m_trans_i[1] = 1'b1;
        ready_i = 1'b1; rdata_i = 32'h0000_6666;
        exp_q.push_back('{0, 1'b0, 32'h0000_6666});
        @(negedge clk);
        checks++;
        if (trans_o !== 1'b0 || addr_o !== 32'h0 || gvec() !== 2'b00 || rvec() !== 2'b00 || svec() !== 2'b00 || m_rdata_o !== 32'h0) begin
            errors++; $display("FAIL rstmid_outputs: trans_o=%b addr_o=%h grant=%b ready=%b resp=%b rdata=%h, expected all 0", trans_o, addr_o, gvec(), rvec(), svec(), m_rdata_o);
        end
        @(negedge clk);
        checks++;
        if (gvec() !== 2'b01 || addr_o !== 32'h60) begin
            errors++; $display("FAIL rstmid_ptr: grant=%b addr_o=%h, expected 01/60", gvec(), addr_o);
        end
        @(negedge clk);
        who = done_master();
        checks++;
        if (who < 0 || exp_q.size() == 0) begin
            errors++; $display("FAIL rstmid_m0_done: no completion, expected master 0");
        end else begin
            e = exp_q.pop_front();
            $display("txn master %0d resp %b rdata %h", who, m_resp_o[who], m_rdata_o);
            if (who !== e.master || m_resp_o[who] !== e.resp || m_rdata_o !== e.rdata) begin
                errors++; $display("FAIL rstmid_m0_done: master %0d resp %b rdata %h, expected %0d %b %h", who, m_resp_o[who], m_rdata_o, e.master, e.resp, e.rdata);
            end
        end
        @(posedge clk); #1;
        m_trans_i[0] = 1'b0; rdata_i = 32'h0000_5151;
        exp_q.push_back('{1, 1'b0, 32'h0000_5151});
        @(negedge clk);
        checks++;
        if (trans_o !== 1'b1 || gvec() !== 2'b10 || addr_o !== 32'h50) begin
            errors++; $display("FAIL rstmid_b2b: trans_o=%b grant=%b addr_o=%h, expected 1/10/50", trans_o, gvec(), addr_o);
        end
        @(negedge clk);
        who = done_master();
        checks++;
        if (who < 0 || exp_q.size() == 0) begin
            errors++; $display("FAIL rstmid_m1_done: no completion, expected master 1");
        end else begin
            e = exp_q.pop_front();
            $display("txn master %0d resp %b rdata %h", who, m_resp_o[who], m_rdata_o);
            if (who !== e.master || m_resp_o[who] !== e.resp || m_rdata_o !== e.rdata) begin
                errors++; $display("FAIL rstmid_m1_done: master %0d resp %b rdata %h, expected %0d %b %h", who, m_resp_o[who], m_rdata_o, e.master, e.resp, e.rdata);
            end
        end
        @(posedge clk); #1;
        m_trans_i[1] = 1'b0; ready_i = 1'b0;
    endtask

    task automatic test_withdrawn();
        exp_t e;
        int   who;
        @(posedge clk); #1;
        m_addr_i[1] = 32'h0000_0070; m_trans_i[1] = 1'b1;
        ready_i = 1'b0; resp_i = 1'b0;
        exp_q.push_back('{1, 1'b0, 32'h0000_7070});
        @(posedge clk);
        @(posedge clk); #1;
        m_trans_i[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (gvec() !== 2'b10) begin
            errors++; $display("FAIL withdraw_owner1: grant=%b, expected 10", gvec());
        end
        @(posedge clk); #1;
        m_trans_i[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (gvec() !== 2'b10) begin
            errors++; $display("FAIL withdraw_owner2: grant=%b, expected 10", gvec());
        end
        @(posedge clk); #1;
        ready_i = 1'b1; rdata_i = 32'h0000_7070;
        @(negedge clk);
        who = done_master();
        checks++;
        if (who < 0 || exp_q.size() == 0) begin
            errors++; $display("FAIL withdraw_done: no completion, expected master 1");
        end else begin
            e = exp_q.pop_front();
            $display("txn master %0d resp %b rdata %h", who, m_resp_o[who], m_rdata_o);
            if (who !== e.master || m_resp_o[who] !== e.resp || m_rdata_o !== e.rdata) begin
                errors++; $display("FAIL withdraw_done: master %0d resp %b rdata %h, expected %0d %b %h", who, m_resp_o[who], m_rdata_o, e.master, e.resp, e.rdata);
            end
        end
        @(posedge clk); #1;
        m_trans_i[1] = 1'b0; ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (trans_o !== 1'b0 || gvec() !== 2'b00 || rvec() !== 2'b00) begin
                errors++; $display("FAIL withdraw_idle: cycle %0d trans_o=%b grant=%b ready=%b, expected 0/00/00", i, trans_o, gvec(), rvec());
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        m_trans_i[0] = 1'b0; m_trans_i[1] = 1'b0;
        m_addr_i[0] = 32'h0; m_addr_i[1] = 32'h0;
        rdata_i = 32'h0; resp_i = 1'b0; ready_i = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_wait();
        test_timeout();
        test_reset_mid();
        test_withdrawn();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d expected completions never seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1, "global timeout");
    end
endmodule
